// File: rtl/fetch_prefetch_unit.sv
// Pipelined instruction fetch front end: credit-limited memory requester feeding
// an in-order prefetch queue, with redirect flush and stale-response dropping.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h8000_0000,
  parameter int unsigned     QUEUE_DEPTH     = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         redirect_i,
  input  logic [XLEN-1:0]              redirect_pc_i,
  output logic                         mem_req_o,
  output logic [XLEN-1:0]              mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         instr_valid_o,
  output logic [31:0]                  instr_o,
  output logic [XLEN-1:0]              instr_pc_o,
  input  logic                         instr_ready_i,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count_o,
  output logic                         fetch_idle_o
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = 32;

  logic [XLEN-1:0]  fetch_pc_r;
  logic [XLEN-1:0]  resp_pc_r;
  logic [OUT_W-1:0] outstanding_r;
  logic [OUT_W-1:0] drop_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [31:0]      instr_q_r [QUEUE_DEPTH];
  logic [XLEN-1:0]  pc_q_r    [QUEUE_DEPTH];

  logic             credit_ok_s;
  logic             req_s;
  logic             grant_s;
  logic             rsp_s;
  logic             push_s;
  logic             valid_s;
  logic             pop_s;
  logic [OUT_W-1:0] out_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [XLEN-1:0]  redirect_addr_s;

  assign redirect_addr_s = {redirect_pc_i[XLEN-1:2], 2'b00};

  // Issue credit, handshakes and next-state counters.
  always_comb begin
    credit_ok_s = (SUM_W'(outstanding_r) < SUM_W'(MAX_OUTSTANDING)) &&
                  ((SUM_W'(outstanding_r) + SUM_W'(count_r)) < SUM_W'(QUEUE_DEPTH));
    req_s       = rst_ni & enable_i & ~redirect_i & credit_ok_s;
    grant_s     = req_s & mem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_s       = mem_rvalid_i & (outstanding_r != {OUT_W{1'b0}});
    push_s      = rsp_s & (drop_r == {OUT_W{1'b0}}) & ~redirect_i;
    valid_s     = (count_r != {CNT_W{1'b0}}) & ~redirect_i;
    pop_s       = valid_s & instr_ready_i;
    out_nxt_s   = outstanding_r + OUT_W'(grant_s) - OUT_W'(rsp_s);
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // PCs, in-flight accounting and queue pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= {OUT_W{1'b0}};
      drop_r        <= {OUT_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
    end else if (redirect_i) begin
      // Everything still in flight after this cycle's response belongs to the old stream.
      fetch_pc_r    <= redirect_addr_s;
      resp_pc_r     <= redirect_addr_s;
      outstanding_r <= out_nxt_s;
      drop_r        <= out_nxt_s;
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
    end else begin
      outstanding_r <= out_nxt_s;
      count_r       <= count_nxt_s;
      if (grant_s) begin
        fetch_pc_r <= fetch_pc_r + XLEN'(32'd4);
      end
      if (rsp_s && (drop_r != {OUT_W{1'b0}})) begin
        drop_r <= drop_r - OUT_W'(1'b1);
      end
      if (push_s) begin
        resp_pc_r <= resp_pc_r + XLEN'(32'd4);
        wr_ptr_r  <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
    end
  end

  // Prefetch queue storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        instr_q_r[i] <= 32'h0000_0000;
        pc_q_r[i]    <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      instr_q_r[wr_ptr_r] <= mem_rdata_i;
      pc_q_r[wr_ptr_r]    <= resp_pc_r;
    end else begin
      instr_q_r[wr_ptr_r] <= instr_q_r[wr_ptr_r];
      pc_q_r[wr_ptr_r]    <= pc_q_r[wr_ptr_r];
    end
  end

  // Output drive; head contents are masked while not valid.
  always_comb begin
    mem_req_o     = req_s;
    mem_addr_o    = fetch_pc_r;
    instr_valid_o = valid_s;
    queue_count_o = count_r;
    fetch_idle_o  = (outstanding_r == {OUT_W{1'b0}}) && (count_r == {CNT_W{1'b0}});
    if (valid_s) begin
      instr_o    = instr_q_r[rd_ptr_r];
      instr_pc_o = pc_q_r[rd_ptr_r];
    end else begin
      instr_o    = 32'h0000_0000;
      instr_pc_o = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: in-order memory responder (one cycle
// after grant) and hand-derived cycle-by-cycle expectations.
module tb_fetch_prefetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [2:0]  queue_count_o;
  logic        fetch_idle_o;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] pend[$];
  logic        resp_en;
  logic        spurious;

  fetch_prefetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .queue_count_o (queue_count_o),
    .fetch_idle_o  (fetch_idle_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC001_D00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    if (spurious) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0_BAD0;
    end else if (resp_en && pend.size() > 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(pend[0]);
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0000_0000;
    end
  endtask

  // Log this cycle's response/grant, cross the rising edge, set up the next cycle.
  task automatic tick();
    if (mem_rvalid_i && pend.size() > 0) void'(pend.pop_front());
    if (mem_req_o && mem_gnt_i) pend.push_back(mem_addr_o);
    @(posedge clk_i);
    @(negedge clk_i);
    drive_mem();
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; enable_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    instr_ready_i = 1'b1; resp_en = 1'b1; spurious = 1'b0;
    #2;
    chk("rst_req",   32'(mem_req_o),     32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o,            32'd0);
    chk("rst_pc",    instr_pc_o,         32'd0);
    chk("rst_count", 32'(queue_count_o), 32'd0);
    chk("rst_idle",  32'(fetch_idle_o),  32'd1);

    @(negedge clk_i);
    rst_ni = 1'b1;
    drive_mem();
    #1;
    // C0: first request straight after release
    chk("c0_req",  32'(mem_req_o), 32'd1);
    chk("c0_addr", mem_addr_o,     32'h8000_0000);
    tick();
    chk("c1_valid", 32'(instr_valid_o), 32'd0);
    chk("c1_addr",  mem_addr_o,         32'h8000_0004);
    tick();
    // C2..C7: one instruction per cycle
    for (int i = 0; i < 6; i++) begin
      chk("run_valid", 32'(instr_valid_o), 32'd1);
      chk("run_pc",    instr_pc_o,         32'h8000_0000 + 32'(4 * i));
      chk("run_instr", instr_o,            mem_word(32'h8000_0000 + 32'(4 * i)));
      chk("run_addr",  mem_addr_o,         32'h8000_0008 + 32'(4 * i));
      chk("run_count", 32'(queue_count_o), 32'd1);
      tick();
    end

    // C8..C17: Decode stalls, queue fills to depth
    instr_ready_i = 1'b0;
    repeat (9) tick();
    chk("stall_count", 32'(queue_count_o), 32'd4);
    chk("stall_req",   32'(mem_req_o),     32'd0);
    chk("stall_valid", 32'(instr_valid_o), 32'd1);
    chk("stall_pc",    instr_pc_o,         32'h8000_0018);
    chk("stall_idle",  32'(fetch_idle_o),  32'd0);
    tick();
    instr_ready_i = 1'b1;
    #1;
    chk("resume_req", 32'(mem_req_o), 32'd0);
    // C18..C23: in-order drain with no gaps
    for (int i = 0; i < 6; i++) begin
      chk("resume_valid", 32'(instr_valid_o), 32'd1);
      chk("resume_pc",    instr_pc_o,         32'h8000_0018 + 32'(4 * i));
      chk("resume_instr", instr_o,            mem_word(32'h8000_0018 + 32'(4 * i)));
      tick();
    end

    // C24..C26: grant withheld, request held stable
    mem_gnt_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("nogrant_req",  32'(mem_req_o), 32'd1);
      chk("nogrant_addr", mem_addr_o,     32'h8000_003C);
      tick();
    end
    mem_gnt_i = 1'b1;
    #1;
    chk("grant_addr",  mem_addr_o,         32'h8000_003C);
    chk("grant_valid", 32'(instr_valid_o), 32'd0);
    tick();
    chk("after_grant_addr", mem_addr_o, 32'h8000_0040);
    tick();
    chk("after_grant_pc",    instr_pc_o, 32'h8000_003C);
    chk("after_grant_instr", instr_o,    mem_word(32'h8000_003C));

    // Hold responses back to build two outstanding reads, then redirect
    resp_en = 1'b0;
    tick();
    chk("c30_addr", mem_addr_o, 32'h8000_0048);
    chk("c30_pc",   instr_pc_o, 32'h8000_0040);
    tick();
    chk("two_out_req", 32'(mem_req_o), 32'd0);
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0102; resp_en = 1'b1;
    #1;
    chk("redir_valid", 32'(instr_valid_o), 32'd0);
    chk("redir_req",   32'(mem_req_o),     32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("redir1_valid", 32'(instr_valid_o), 32'd0);
    chk("redir1_req",   32'(mem_req_o),     32'd0);
    tick();
    chk("redir2_req",   32'(mem_req_o),     32'd1);
    chk("redir2_addr",  mem_addr_o,         32'h8000_0100);
    chk("redir2_valid", 32'(instr_valid_o), 32'd0);
    tick();
    chk("redir3_valid", 32'(instr_valid_o), 32'd0);
    chk("redir3_addr",  mem_addr_o,         32'h8000_0104);
    tick();
    chk("redir_first_valid", 32'(instr_valid_o), 32'd1);
    chk("redir_first_pc",    instr_pc_o,         32'h8000_0100);
    chk("redir_first_instr", instr_o,            mem_word(32'h8000_0100));
    tick();

    // C36: redirect coincides with a response
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    #1;
    chk("rv_redir_valid", 32'(instr_valid_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("rv_redir1_req",   32'(mem_req_o),     32'd1);
    chk("rv_redir1_addr",  mem_addr_o,         32'h8000_0200);
    chk("rv_redir1_valid", 32'(instr_valid_o), 32'd0);
    tick();
    chk("rv_redir2_valid", 32'(instr_valid_o), 32'd0);
    tick();
    chk("rv_redir3_valid", 32'(instr_valid_o), 32'd1);
    chk("rv_redir3_pc",    instr_pc_o,         32'h8000_0200);
    chk("rv_redir3_instr", instr_o,            mem_word(32'h8000_0200));

    // Reset mid-stream
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_req",   32'(mem_req_o),     32'd0);
    chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    chk("mid_rst_instr", instr_o,            32'd0);
    chk("mid_rst_pc",    instr_pc_o,         32'd0);
    chk("mid_rst_count", 32'(queue_count_o), 32'd0);
    chk("mid_rst_idle",  32'(fetch_idle_o),  32'd1);
    pend.delete();
    spurious = 1'b1;
    tick();
    rst_ni = 1'b1;
    #1;
    chk("restart_req",  32'(mem_req_o), 32'd1);
    chk("restart_addr", mem_addr_o,     32'h8000_0000);
    spurious = 1'b0;
    tick();
    chk("spurious_valid", 32'(instr_valid_o), 32'd0);
    chk("spurious_count", 32'(queue_count_o), 32'd0);
    tick();
    chk("restart_valid", 32'(instr_valid_o), 32'd1);
    chk("restart_pc",    instr_pc_o,         32'h8000_0000);
    chk("restart_instr", instr_o,            mem_word(32'h8000_0000));

    // Disable fetch and drain to idle
    enable_i = 1'b0;
    #1;
    chk("disable_req", 32'(mem_req_o), 32'd0);
    repeat (4) tick();
    chk("drain_idle",  32'(fetch_idle_o),  32'd1);
    chk("drain_count", 32'(queue_count_o), 32'd0);
    chk("drain_valid", 32'(instr_valid_o), 32'd0);
    chk("drain_req",   32'(mem_req_o),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction fetch front end for the Fetch stage. It replaces the single-shot, two-cycle fetch with a pipelined requester that keeps up to MAX_OUTSTANDING memory reads in flight and buffers returned words in a QUEUE_DEPTH-entry prefetch queue. It supports PC redirects from later stages, and hands instructions to Decode over a valid/ready handshake. It sits between the instruction memory port and the Decode stage.

## Interface
- XLEN, 32, address/PC width
- RESET_PC, 32'h8000_0000, first fetch address after reset
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, >= 2
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; 1..QUEUE_DEPTH

- clk_i  input  1  clock; all state updates on its rising edge
- rst_ni  input  1  reset; one clock, reset asynchronous and active-low
- enable_i  input  1  fetch enable; low stops new requests only
- redirect_i  input  1  flush and restart at redirect_pc_i
- redirect_pc_i  input  XLEN  new PC; bits [1:0] ignored (forced 0)
- mem_req_o  output  1  read request
- mem_addr_o  output  XLEN  request address (word aligned)
- mem_gnt_i  input  1  request accepted this cycle
- mem_rvalid_i  input  1  read data valid; responses in request order, at least 1 cycle after grant
- mem_rdata_i  input  32  read data
- instr_valid_o  output  1  queue head valid
- instr_o  output  32  head instruction
- instr_pc_o  output  XLEN  PC of head instruction
- instr_ready_i  input  1  Decode accepts head
- queue_count_o  output  $clog2(QUEUE_DEPTH)+1  occupied entries
- fetch_idle_o  output  1  no outstanding requests and queue empty

## Operation
- State: fetch_pc, resp_pc (PC of next expected response), outstanding counter, drop counter, circular queue (instr, pc) with rd/wr pointers and count.
- Issue: mem_req_o = enable_i & ~redirect_i & (outstanding < MAX_OUTSTANDING) & (outstanding + count < QUEUE_DEPTH); mem_addr_o = fetch_pc. Grant = mem_req_o & mem_gnt_i; on grant fetch_pc += 4 (wraps modulo 2^XLEN), outstanding += 1.
- Credit rule guarantees a free slot for every non-dropped response; queue never overflows.
- Response: on mem_rvalid_i, outstanding -= 1. If drop > 0: drop -= 1, data discarded. Otherwise push {mem_rdata_i, resp_pc}, resp_pc += 4.
- Pop: instr_valid_o & instr_ready_i advances rd pointer. Push and pop in same cycle leave count unchanged.
- Outputs: instr_valid_o = (count != 0) & ~redirect_i; instr_o/instr_pc_o = head entry when valid, else 0.
- Redirect (priority over everything): queue flushed (count 0), fetch_pc and resp_pc <= {redirect_pc_i[XLEN-1:2], 2'b00}, no request issued, drop <= outstanding after accounting this cycle's mem_rvalid_i (a response arriving in the redirect cycle is itself discarded). Pop in a redirect cycle does not occur.
- enable_i low: no new requests; outstanding responses still accepted and queued; Decode drains normally.
- mem_rvalid_i with outstanding == 0 is a protocol error; ignored, counters unchanged.

## Timing
- Reset (rst_ni low, asynchronous): fetch_pc = resp_pc = RESET_PC, outstanding = drop = 0, queue empty; mem_req_o 0, instr_valid_o 0, instr_o 0, instr_pc_o 0, queue_count_o 0, fetch_idle_o 1. Reset mid-operation discards all in-flight state; responses after reset release are treated as errors per above.
- First mem_req_o in the first cycle after reset release with enable_i high.
- Latency: grant at cycle N, response at N+k -> instr_valid_o at N+k+1 (no bypass).
- Redirect at cycle R: instr_valid_o low in R and R+1 (queue empty); new request to redirect PC in R+1 if credit allows.
- Throughput: one instruction per cycle sustained when memory grants every cycle and returns with latency <= MAX_OUTSTANDING.

## Test plan
- Reset, enable high, memory grants every cycle, 1-cycle data latency, ready high -> addresses 8000_0000, 8000_0004, ... one per cycle; instr_pc_o matches each word; valid continuous after startup.
- instr_ready_i low for 10 cycles -> queue_count_o reaches 4, mem_req_o drops, no data loss; resume -> in-order delivery.
- mem_gnt_i low 3 cycles -> mem_req_o held, mem_addr_o stable at same address until grant.
- Redirect to 8000_0102 with 2 outstanding -> both stale responses dropped, next request 8000_0100, first delivered instr_pc_o 8000_0100.
- Redirect in same cycle as mem_rvalid_i -> that word discarded, drop counts remaining outstanding only.
- Assert rst_ni mid-stream -> outputs immediately at reset values; after release fetch restarts at 8000_0000.
